lc3_mem_responder: RTL and testbench
====================================

# lc3_mem_responder

Memory-side responder for the LC-3 datapath. It accepts read and write requests driven from the CPU's MAR/MDR and returns read data for the MDR input path. It services each request from an on-chip word array or a memory-mapped I/O register after a fixed, parameterized number of wait states, and signals completion with a one-cycle ready pulse (R) that the control FSM waits on in its memory states.

## Interface
- WAIT_CYCLES, 2: wait states between request acceptance and the commit/ready edge; legal range 0..15.
- ADDR_BITS, 8: the on-chip array holds 2^ADDR_BITS 16-bit words at addresses 0..2^ADDR_BITS-1.
- IO_ADDR, 16'hFFFF: memory-mapped I/O address (switches/hex).

- Clk  input  1  system clock, rising-edge active.
- Reset  input  1  asynchronous, active-low reset.
- Mem_Req  input  1  request strobe; sampled only in IDLE.
- Mem_WE  input  1  1 = write, 0 = read; latched with the request.
- Addr  input  16  word address (MAR_Out); latched with the request.
- Data_From_CPU  input  16  write data (MDR_Out); latched with the request.
- Switches  input  16  I/O read source.
- Data_To_CPU  output  16  read data (feeds MDR_In); holds the last read result.
- R  output  1  ready; one-cycle pulse per completed request.
- Busy  output  1  high while a request is in flight (state != IDLE).
- Addr_Err  output  1  one-cycle pulse coincident with R for an unmapped address.
- HEX_Data  output  16  I/O write register (drives hex displays).

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Mem_Req=1 at an edge latches Addr, Mem_WE and Data_From_CPU.
  - Goes to WAIT with counter = WAIT_CYCLES-1, or directly to RESP if WAIT_CYCLES=0.
  - Mem_Req=0 stays in IDLE.
- WAIT: the counter decrements each cycle. At 0, the next edge is the commit edge and the state goes to RESP.
- Commit edge actions, by latched address:
  - In-array write: writes the word.
  - In-array read: loads Data_To_CPU with the word.
  - IO_ADDR write: loads HEX_Data.
  - IO_ADDR read: loads Data_To_CPU with Switches as sampled at that edge.
  - Unmapped write (Addr >= 2^ADDR_BITS and != IO_ADDR): dropped; Addr_Err=1 during RESP.
  - Unmapped read: Data_To_CPU loads 16'h0000; Addr_Err=1 during RESP.
- RESP: lasts one cycle with R=1, then returns unconditionally to IDLE.
- New requests:
  - Mem_Req is not sampled in RESP.
  - Mem_Req still high in the following IDLE cycle starts a new transaction.
- Input changes after the acceptance edge do not affect the transaction in flight.
- Writes never modify Data_To_CPU. Reads never modify HEX_Data or array contents.
- A read at the address just written returns the new value. The array is not read-during-write ambiguous because operations are serialized.

## Timing
- Acceptance edge E0.
  - Commit edge: E0+WAIT_CYCLES.
  - R, Addr_Err and the new Data_To_CPU are visible from the commit edge until one edge later (Data_To_CPU holds thereafter).
- Throughput: one request per WAIT_CYCLES+2 cycles when Mem_Req is held high.
- Busy:
  - Rises at E0.
  - Falls at the edge ending RESP.
- Reset asserted at any time:
  - State = IDLE.
  - R, Busy, Addr_Err = 0.
  - Data_To_CPU and HEX_Data = 16'h0000.
  - Counter cleared.
  - An in-flight write whose commit edge has not occurred is discarded.
  - Array contents are not reset.
- Reset deassertion: the first edge with Reset high may accept a request.

## Structure
- Package lc3_mem_pkg holds:
  - the state enum (IDLE, WAIT, RESP);
  - the IO_ADDR default constant;
  - a request struct (addr, we, wdata).
- Sub-module lc3_mem_array: single-port synchronous RAM, 16-bit words, 2^ADDR_BITS depth, write enable, registered read, no reset.
- Top level holds the FSM, counter, address decode, HEX_Data and Data_To_CPU registers.

## Test plan
- Write and read back, WAIT_CYCLES=2:
  - Stimulus: write 16'hBEEF to 16'h0010 accepted at E0, then read 16'h0010.
  - Response: first R at E0+2. The read returns 16'hBEEF with R pulsing exactly one cycle, and Busy high for exactly 3 cycles per request.
- Zero wait states, WAIT_CYCLES=0, Mem_Req held high for 4 requests:
  - Response: R at E0, E0+2, E0+4, E0+6.
- I/O mapping:
  - Stimulus: write 16'h1234 to 16'hFFFF; then read 16'hFFFF with Switches=16'h00A5.
  - Response: HEX_Data=16'h1234; Data_To_CPU=16'h00A5; array contents unchanged.
- Unmapped address, ADDR_BITS=8:
  - Stimulus: read 16'h0100.
  - Response: Data_To_CPU=16'h0000 with Addr_Err=R=1 for one cycle.
  - Stimulus: write 16'h0100.
  - Response: does not alias into word 16'h0000.
- Reset mid-write:
  - Stimulus: assert Reset one cycle after accepting a write of 16'h5555 to 16'h0003 (WAIT_CYCLES=2).
  - Response: all outputs 0 immediately; a later read of 16'h0003 returns its prior value.
- Latching:
  - Stimulus: change Addr and Data_From_CPU during WAIT.
  - Response: the commit uses the values sampled at E0.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// lc3_mem_pkg: shared types and constants for the LC-3 memory responder.
package lc3_mem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [15:0] IO_ADDR_DEF = 16'hFFFF;

    typedef struct packed {
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
    } req_t;

endpackage

// File: rtl/lc3_mem_array.sv
// lc3_mem_array: single-port synchronous RAM, 16-bit words, registered read, no reset.
module lc3_mem_array
    import lc3_mem_pkg::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [15:0]          wdata,
    output logic [15:0]          rdata
);

    logic [15:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        if (re)
            rdata <= mem[addr];
    end

endmodule

// File: rtl/lc3_mem_responder.sv
// lc3_mem_responder: wait-stated memory/IO responder for the LC-3 MAR/MDR path.
module lc3_mem_responder
    import lc3_mem_pkg::*;
#(
    parameter int          WAIT_CYCLES = 2,
    parameter int          ADDR_BITS   = 8,
    parameter logic [15:0] IO_ADDR     = IO_ADDR_DEF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Mem_Req,
    input  logic        Mem_WE,
    input  logic [15:0] Addr,
    input  logic [15:0] Data_From_CPU,
    input  logic [15:0] Switches,
    output logic [15:0] Data_To_CPU,
    output logic        R,
    output logic        Busy,
    output logic        Addr_Err,
    output logic [15:0] HEX_Data
);

    state_t      state, state_n;
    req_t        req_q, req_c;
    logic [3:0]  cnt;
    logic        accept, commit, in_array, is_io, ram_we, ram_re;
    logic        src_ram, err_q;
    logic [15:0] data_q, ram_q;

    // With zero wait states the acceptance edge is also the commit edge,
    // so the live inputs must be decoded directly while IDLE.
    always_comb begin
        req_c    = (state == IDLE) ? {Addr, Mem_WE, Data_From_CPU} : req_q;
        accept   = (state == IDLE) && Mem_Req;
        commit   = Reset && ((accept && WAIT_CYCLES == 0) || (state == WAIT && cnt == 4'd0));
        is_io    = req_c.addr == IO_ADDR;
        in_array = ((req_c.addr >> ADDR_BITS) == 16'h0) && !is_io;
        ram_we   = commit && req_c.we && in_array;
        ram_re   = commit && !req_c.we && in_array;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = Mem_Req ? ((WAIT_CYCLES == 0) ? RESP : WAIT) : IDLE;
            WAIT:    state_n = (cnt == 4'd0) ? RESP : WAIT;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            req_q    <= '0;
            err_q    <= 1'b0;
            src_ram  <= 1'b0;
            data_q   <= 16'h0000;
            HEX_Data <= 16'h0000;
        end else begin
            state <= state_n;
            err_q <= commit && !in_array && !is_io;
            if (accept) begin
                req_q <= req_c;
                cnt   <= (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            // Array reads return through the RAM's own output register.
            if (commit && !req_c.we) begin
                src_ram <= in_array;
                data_q  <= is_io ? Switches : 16'h0000;
            end
            if (commit && req_c.we && is_io)
                HEX_Data <= req_c.wdata;
        end
    end

    lc3_mem_array #(.ADDR_BITS(ADDR_BITS)) u_array (
        .clk   (Clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (req_c.addr[ADDR_BITS-1:0]),
        .wdata (req_c.wdata),
        .rdata (ram_q)
    );

    assign Data_To_CPU = src_ram ? ram_q : data_q;
    assign R           = state == RESP;
    assign Busy        = state != IDLE;
    assign Addr_Err    = err_q;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// tb_lc3_mem_responder: directed checks of the memory responder at 2 and 0 wait states.
module tb_lc3_mem_responder;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Mem_Req = 1'b0;
    logic        Mem_WE = 1'b0;
    logic [15:0] Addr = 16'h0;
    logic [15:0] Data_From_CPU = 16'h0;
    logic [15:0] Switches = 16'h0;
    logic [15:0] Data_To_CPU, HEX_Data, z_Data, z_HEX;
    logic        R, Busy, Addr_Err, z_R, z_Busy, z_Err;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 Clk = ~Clk;

    lc3_mem_responder #(.WAIT_CYCLES(2), .ADDR_BITS(8)) dut (
        .Clk(Clk), .Reset(Reset), .Mem_Req(Mem_Req), .Mem_WE(Mem_WE),
        .Addr(Addr), .Data_From_CPU(Data_From_CPU), .Switches(Switches),
        .Data_To_CPU(Data_To_CPU), .R(R), .Busy(Busy), .Addr_Err(Addr_Err),
        .HEX_Data(HEX_Data)
    );

    lc3_mem_responder #(.WAIT_CYCLES(0), .ADDR_BITS(8)) dut0 (
        .Clk(Clk), .Reset(Reset), .Mem_Req(Mem_Req), .Mem_WE(Mem_WE),
        .Addr(Addr), .Data_From_CPU(Data_From_CPU), .Switches(Switches),
        .Data_To_CPU(z_Data), .R(z_R), .Busy(z_Busy), .Addr_Err(z_Err),
        .HEX_Data(z_HEX)
    );

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic we, input logic [15:0] a, input logic [15:0] d);
        Mem_Req = 1'b1;
        Mem_WE = we;
        Addr = a;
        Data_From_CPU = d;
        tick;
        Mem_Req = 1'b0;
    endtask

    // Leaves the bench sampling just after the commit edge (E0+2).
    task automatic run(input logic we, input logic [15:0] a, input logic [15:0] d);
        start(we, a, d);
        tick;
        tick;
    endtask

    initial begin
        tick;
        tick;
        chk("rst_data", Data_To_CPU, 16'h0000);
        chk("rst_hex", HEX_Data, 16'h0000);
        chk("rst_r", R, 1'b0);
        chk("rst_busy", Busy, 1'b0);
        chk("rst_err", Addr_Err, 1'b0);
        Reset = 1'b1;
        tick;
        chk("idle_busy", Busy, 1'b0);

        start(1'b1, 16'h0010, 16'hBEEF);
        chk("wr_e0_busy", Busy, 1'b1);
        chk("wr_e0_r", R, 1'b0);
        tick;
        chk("wr_e1_busy", Busy, 1'b1);
        chk("wr_e1_r", R, 1'b0);
        tick;
        chk("wr_e2_r", R, 1'b1);
        chk("wr_e2_busy", Busy, 1'b1);
        chk("wr_e2_err", Addr_Err, 1'b0);
        chk("wr_no_data", Data_To_CPU, 16'h0000);
        tick;
        chk("wr_e3_r", R, 1'b0);
        chk("wr_e3_busy", Busy, 1'b0);

        run(1'b0, 16'h0010, 16'h0000);
        chk("rd_r", R, 1'b1);
        chk("rd_data", Data_To_CPU, 16'hBEEF);
        tick;
        chk("rd_r_off", R, 1'b0);
        chk("rd_busy_off", Busy, 1'b0);
        chk("rd_hold", Data_To_CPU, 16'hBEEF);

        run(1'b1, 16'h00FF, 16'h7777);
        tick;
        run(1'b1, 16'hFFFF, 16'h1234);
        chk("io_hex", HEX_Data, 16'h1234);
        chk("io_wr_data", Data_To_CPU, 16'hBEEF);
        tick;
        Switches = 16'h00A5;
        run(1'b0, 16'hFFFF, 16'h0000);
        chk("io_rd", Data_To_CPU, 16'h00A5);
        Switches = 16'h0000;
        tick;
        chk("io_rd_hex", HEX_Data, 16'h1234);
        run(1'b0, 16'h00FF, 16'h0000);
        chk("io_no_alias", Data_To_CPU, 16'h7777);
        tick;

        run(1'b1, 16'h0000, 16'h1111);
        tick;
        run(1'b0, 16'h0100, 16'h0000);
        chk("um_rd_data", Data_To_CPU, 16'h0000);
        chk("um_rd_err", Addr_Err, 1'b1);
        chk("um_rd_r", R, 1'b1);
        tick;
        chk("um_err_off", Addr_Err, 1'b0);
        run(1'b1, 16'h0100, 16'h2222);
        chk("um_wr_err", Addr_Err, 1'b1);
        tick;
        run(1'b0, 16'h0000, 16'h0000);
        chk("um_no_alias", Data_To_CPU, 16'h1111);
        chk("um_ok_err", Addr_Err, 1'b0);
        tick;

        run(1'b1, 16'h0021, 16'h0C0C);
        tick;
        start(1'b1, 16'h0020, 16'hAAAA);
        Addr = 16'h0021;
        Data_From_CPU = 16'h5555;
        Mem_WE = 1'b0;
        tick;
        tick;
        chk("lat_r", R, 1'b1);
        tick;
        run(1'b0, 16'h0020, 16'h0000);
        chk("lat_addr", Data_To_CPU, 16'hAAAA);
        tick;
        run(1'b0, 16'h0021, 16'h0000);
        chk("lat_other", Data_To_CPU, 16'h0C0C);
        tick;

        run(1'b1, 16'h0003, 16'h3333);
        tick;
        run(1'b0, 16'h0003, 16'h0000);
        chk("mid_pre", Data_To_CPU, 16'h3333);
        tick;
        start(1'b1, 16'h0003, 16'h5555);
        tick;
        Reset = 1'b0;
        #1;
        chk("mid_data", Data_To_CPU, 16'h0000);
        chk("mid_hex", HEX_Data, 16'h0000);
        chk("mid_r", R, 1'b0);
        chk("mid_busy", Busy, 1'b0);
        chk("mid_err", Addr_Err, 1'b0);
        tick;
        Reset = 1'b1;
        run(1'b0, 16'h0003, 16'h0000);
        chk("mid_kept", Data_To_CPU, 16'h3333);
        tick;

        Mem_Req = 1'b1;
        Mem_WE = 1'b0;
        Addr = 16'h0010;
        for (int i = 0; i < 7; i++) begin
            tick;
            chk("zw_r", z_R, 16'((i % 2) == 0));
            if (i == 0)
                chk("zw_data", z_Data, 16'hBEEF);
        end
        Mem_Req = 1'b0;
        tick;
        chk("zw_r_end", z_R, 1'b0);
        chk("zw_busy_end", z_Busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
